// File: rtl/midori64_pkg.sv
// rtl/midori64_pkg.sv - Midori64 tables, round constants and share-wise linear layer
package midori64_pkg;

  localparam int NUM_SHARES = 3;
  localparam int NUM_CELLS  = 16;
  localparam int STATIC_W   = 12;
  localparam int DYNAMIC_W  = 2;
  localparam int NUM_TERMS  = 81;
  localparam int FINAL_CNT  = 30;

  localparam logic [3:0] SB0 [16] = '{
    4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
    4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  localparam int SHUFFLE [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};

  // Bit 15 is cell 0; entry 15 is zero so the saturated counter indexes harmlessly.
  localparam logic [15:0] ALPHA [16] = '{
    16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F, 16'hD170, 16'h0266, 16'h0BCC,
    16'h9481, 16'h40B8, 16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90, 16'h0000
  };

  function automatic logic [63:0] shuffle_mix(input logic [63:0] s);
    logic [63:0] p;
    logic [63:0] m;
    int          b;
    for (int c = 0; c < NUM_CELLS; c++) begin
      p[60-4*c +: 4] = s[60-4*SHUFFLE[c] +: 4];
    end
    for (int c = 0; c < NUM_CELLS; c++) begin
      b = c - (c % 4);
      m[60-4*c +: 4] = p[60-4*b +: 4] ^ p[56-4*b +: 4] ^ p[52-4*b +: 4] ^
                       p[48-4*b +: 4] ^ p[60-4*c +: 4];
    end
    return m;
  endfunction

  function automatic logic [63:0] alpha_mask(input logic [3:0] round);
    logic [63:0] m;
    logic [15:0] a;
    m = '0;
    a = ALPHA[round];
    for (int c = 0; c < NUM_CELLS; c++) begin
      m[60-4*c] = a[15-c];
    end
    return m;
  endfunction

endpackage

// File: rtl/midori64_masked_sbox.sv
// rtl/midori64_masked_sbox.sv - three-share cubic Sb0 split by one register stage
module midori64_masked_sbox
  import midori64_pkg::*;
(
  input  logic                       clk,
  input  logic [NUM_SHARES-1:0][3:0] i_x,
  input  logic [STATIC_W-1:0]        i_static_r,
  input  logic [DYNAMIC_W-1:0]       i_dynamic_r,
  output logic [NUM_SHARES-1:0][3:0] o_y
);

  logic [NUM_TERMS-1:0][3:0]  w_terms;
  logic [NUM_TERMS-1:0][3:0]  r_terms;
  logic [NUM_SHARES-1:0][3:0] w_refresh;

  // Zero-sum remask; terms 0..2 are the first terms folded into shares 0..2.
  assign w_refresh[0] = i_static_r[3:0] ^ i_static_r[7:4];
  assign w_refresh[1] = i_static_r[7:4] ^ i_static_r[11:8];
  assign w_refresh[2] = i_static_r[11:8] ^ i_static_r[3:0];

  // Term t applies Sb0 to one share per input bit (base-3 digits of t); over all
  // 81 tuples every monomial appears an odd number of times, so the XOR is Sb0(x).
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [3:0] w_mix;
    assign w_mix = {i_x[(t/27)%3][3], i_x[(t/9)%3][2], i_x[(t/3)%3][1], i_x[t%3][0]};
    if (t < NUM_SHARES) begin : g_fresh
      assign w_terms[t] = SB0[w_mix] ^ w_refresh[t];
    end else begin : g_plain
      assign w_terms[t] = SB0[w_mix];
    end
  end

  always_ff @(posedge clk) begin
    r_terms <= w_terms;
  end

  always_comb begin
    o_y = '0;
    for (int g = 0; g < NUM_TERMS / NUM_SHARES; g++) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        o_y[j] = o_y[j] ^ r_terms[NUM_SHARES*g + j];
      end
    end
    o_y[0] = o_y[0] ^ {2{i_dynamic_r}};
    o_y[1] = o_y[1] ^ {2{i_dynamic_r}};
  end

endmodule

// File: rtl/midori64.sv
// rtl/midori64.sv - round-based 3-share Midori64-128 encryptor, two interleaved blocks
module midori64
  import midori64_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  input1,
  input  logic [63:0]  input2,
  input  logic [63:0]  input3,
  input  logic [127:0] Key1,
  input  logic [127:0] Key2,
  input  logic [127:0] Key3,
  input  logic [191:0] Static_r,
  input  logic [31:0]  Dynamic_r,
  output logic [63:0]  output1,
  output logic [63:0]  output2,
  output logic [63:0]  output3,
  output logic         done
);

  logic [NUM_SHARES-1:0][63:0]  w_plain;
  logic [NUM_SHARES-1:0][63:0]  w_wk;
  logic [NUM_SHARES-1:0][63:0]  w_rk;
  logic [NUM_SHARES-1:0][63:0]  w_sb;
  logic [NUM_SHARES-1:0][63:0]  w_lin;
  logic [NUM_SHARES-1:0][127:0] w_key;
  logic [NUM_SHARES-1:0][63:0]  r_state;
  logic [4:0]                   r_cnt;
  logic [3:0]                   w_round;

  assign w_plain = {input3, input2, input1};
  assign w_key   = {Key3, Key2, Key1};
  // Blocks A and B alternate cycles, so both use round cnt>>1.
  assign w_round = r_cnt[4:1];

  always_comb begin
    for (int j = 0; j < NUM_SHARES; j++) begin
      w_wk[j] = w_key[j][127:64] ^ w_key[j][63:0];
      w_rk[j] = w_round[0] ? w_key[j][63:0] : w_key[j][127:64];
    end
    w_rk[0] = w_rk[0] ^ alpha_mask(w_round);
  end

  always_comb begin
    for (int j = 0; j < NUM_SHARES; j++) begin
      w_lin[j] = shuffle_mix(w_sb[j]) ^ w_rk[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_SHARES; j++) begin
        r_state[j] <= w_plain[j] ^ w_wk[j];
      end
    end else begin
      r_state <= w_lin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt != 5'd31) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  for (genvar n = 0; n < NUM_CELLS; n++) begin : g_sbox
    logic [NUM_SHARES-1:0][3:0] w_x;
    logic [NUM_SHARES-1:0][3:0] w_y;
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_share
      assign w_x[j]               = r_state[j][60-4*n +: 4];
      assign w_sb[j][60-4*n +: 4] = w_y[j];
    end
    midori64_masked_sbox u_sbox (
      .clk         (clk),
      .i_x         (w_x),
      .i_static_r  (Static_r[STATIC_W*n +: STATIC_W]),
      .i_dynamic_r (Dynamic_r[DYNAMIC_W*n +: DYNAMIC_W]),
      .o_y         (w_y)
    );
  end

  assign output1 = w_sb[0] ^ w_wk[0];
  assign output2 = w_sb[1] ^ w_wk[1];
  assign output3 = w_sb[2] ^ w_wk[2];
  assign done    = (r_cnt == 5'(FINAL_CNT));

endmodule

// File: tb/tb_midori64.sv
// tb/tb_midori64.sv - scoreboard bench for midori64 against a cell-level reference model
module tb_midori64;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  input1, input2, input3;
  logic [127:0] Key1, Key2, Key3;
  logic [191:0] Static_r = '0;
  logic [31:0]  Dynamic_r = '0;
  logic [63:0]  output1, output2, output3;
  logic         done;

  midori64 dut (
    .clk(clk), .reset(reset),
    .input1(input1), .input2(input2), .input3(input3),
    .Key1(Key1), .Key2(Key2), .Key3(Key3),
    .Static_r(Static_r), .Dynamic_r(Dynamic_r),
    .output1(output1), .output2(output2), .output3(output3),
    .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_V1 = 128'h687ded3b3c85b3f35b1009863e2a8cbf;

  logic [3:0] SBOX [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                            4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
  int SHUF [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
  bit alpha_bits [15][16] = '{
    '{0,0,0,1,0,1,0,1,1,0,1,1,0,0,1,1}, '{0,1,1,1,1,0,0,0,1,1,0,0,0,0,0,0},
    '{1,0,1,0,0,1,0,0,0,0,1,1,0,1,0,1}, '{0,1,1,0,0,0,1,0,0,0,0,1,0,0,1,1},
    '{0,0,0,1,0,0,0,0,0,1,0,0,1,1,1,1}, '{1,1,0,1,0,0,0,1,0,1,1,1,0,0,0,0},
    '{0,0,0,0,0,0,1,0,0,1,1,0,0,1,1,0}, '{0,0,0,0,1,0,1,1,1,1,0,0,1,1,0,0},
    '{1,0,0,1,0,1,0,0,1,0,0,0,0,0,0,1}, '{0,1,0,0,0,0,0,0,1,0,1,1,1,0,0,0},
    '{0,1,1,1,0,0,0,1,1,0,0,1,0,1,1,1}, '{0,0,1,0,0,0,1,0,1,0,0,0,1,1,1,0},
    '{0,1,0,1,0,0,0,1,0,0,1,1,0,0,0,0}, '{1,1,1,1,1,0,0,0,1,1,0,0,1,0,1,0},
    '{1,1,0,1,1,1,1,1,1,0,0,1,0,0,0,0}
  };

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rel_cyc = 0;
  bit          zero_rand = 1'b0;
  logic [63:0] sb_q [$];
  bit          chk_b = 1'b0;
  logic [63:0] exp_b;
  logic [63:0] last_share1 = '0;

  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [127:0] k);
    logic [3:0]  s [16];
    logic [3:0]  t [16];
    logic [3:0]  k0 [16];
    logic [3:0]  k1 [16];
    logic [3:0]  wk [16];
    logic [63:0] c;
    for (int i = 0; i < 16; i++) begin
      s[i]  = p[60-4*i +: 4];
      k0[i] = k[124-4*i +: 4];
      k1[i] = k[60-4*i +: 4];
      wk[i] = k0[i] ^ k1[i];
      s[i]  = s[i] ^ wk[i];
    end
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 16; i++) t[i] = SBOX[s[SHUF[i]]];
      for (int i = 0; i < 16; i++)
        s[i] = t[4*(i/4)] ^ t[4*(i/4)+1] ^ t[4*(i/4)+2] ^ t[4*(i/4)+3] ^ t[i];
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ ((r % 2 == 1) ? k1[i] : k0[i]) ^ {3'b000, alpha_bits[r][i]};
    end
    c = '0;
    for (int i = 0; i < 16; i++) c = {c[59:0], SBOX[s[i]] ^ wk[i]};
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 6; i++) Static_r[32*i +: 32] = zero_rand ? 32'd0 : $urandom();
    Dynamic_r = zero_rand ? 32'd0 : $urandom();
  end

  always @(negedge clk) begin
    if (chk_b) begin
      check("ct_b", output1 ^ output2 ^ output3, exp_b);
      check("done_pulse_width", {63'b0, done}, 64'd0);
      chk_b = 1'b0;
    end else if (done === 1'b1) begin
      if (sb_q.size() < 2) begin
        check("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        check("ct_a", output1 ^ output2 ^ output3, sb_q.pop_front());
        check("done_latency", 64'(cyc - rel_cyc), 64'd30);
        exp_b       = sb_q.pop_front();
        last_share1 = output1;
        chk_b       = 1'b1;
      end
    end
  end

  task automatic load(input logic [63:0] pa, input logic [63:0] pb,
                      input logic [127:0] k, input bit split);
    logic [63:0]  s2, s3;
    logic [127:0] k2, k3;
    k2   = split ? {$urandom(), $urandom(), $urandom(), $urandom()} : '0;
    k3   = split ? {$urandom(), $urandom(), $urandom(), $urandom()} : '0;
    Key1 = k ^ k2 ^ k3;
    Key2 = k2;
    Key3 = k3;
    reset = 1'b1;
    s2 = split ? {$urandom(), $urandom()} : '0;
    s3 = split ? {$urandom(), $urandom()} : '0;
    input1 = pa ^ s2 ^ s3; input2 = s2; input3 = s3;
    @(negedge clk);
    s2 = split ? {$urandom(), $urandom()} : '0;
    s3 = split ? {$urandom(), $urandom()} : '0;
    input1 = pb ^ s2 ^ s3; input2 = s2; input3 = s3;
    @(negedge clk);
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic run(input logic [63:0] pa, input logic [63:0] pb, input logic [127:0] k,
                     input bit split, input logic [63:0] ea, input logic [63:0] eb);
    sb_q.push_back(ea);
    sb_q.push_back(eb);
    load(pa, pb, k, split);
    repeat (33) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()) + {63'b0, chk_b}, 64'd0);
    sb_q.delete();
    chk_b = 1'b0;
  endtask

  initial begin
    logic [63:0]  zshare, pa, pb;
    logic [127:0] k;
    int           n_hi;
    reset = 1'b1;
    input1 = '0; input2 = '0; input3 = '0;
    Key1 = '0; Key2 = '0; Key3 = '0;
    @(negedge clk);
    check("reset_done", {63'b0, done}, 64'd0);

    run(64'h0, 64'h42c20fd3b586879e, KEY_V1, 1'b0, 64'h36f32dcf124ab057, 64'h66bcdc6270d901cd);
    run(64'h0, 64'h42c20fd3b586879e, KEY_V1, 1'b1, 64'h36f32dcf124ab057, 64'h66bcdc6270d901cd);
    run(64'h0, 64'h0, 128'h0, 1'b0, 64'h3c9cceda2bbd449a, 64'h3c9cceda2bbd449a);

    zero_rand = 1'b1;
    run(64'h0, 64'h42c20fd3b586879e, KEY_V1, 1'b0, 64'h36f32dcf124ab057, 64'h66bcdc6270d901cd);
    zshare    = last_share1;
    zero_rand = 1'b0;
    run(64'h0, 64'h42c20fd3b586879e, KEY_V1, 1'b0, 64'h36f32dcf124ab057, 64'h66bcdc6270d901cd);
    n_tests++;
    if (last_share1 === zshare) begin
      n_fail++;
      $display("FAIL share_differs: random-run share1 %h equals zero-run share1 %h",
               last_share1, zshare);
    end

    load({$urandom(), $urandom()}, {$urandom(), $urandom()},
         {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("abort_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    run(64'h0, 64'h42c20fd3b586879e, KEY_V1, 1'b0, 64'h36f32dcf124ab057, 64'h66bcdc6270d901cd);

    n_hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n_hi++;
    end
    check("saturated_done", 64'(n_hi), 64'd0);

    for (int i = 0; i < 8; i++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      pa = {$urandom(), $urandom()};
      pb = {$urandom(), $urandom()};
      run(pa, pb, k, 1'b1, ref_enc(pa, k), ref_enc(pb, k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
